can_tx_scheduler: RTL and testbench
===================================

# can_tx_scheduler

Transmit scheduler for the CAN controller. It holds per-mailbox pending flags for N requesters and selects the pending frame with the lowest CAN identifier. It loads that frame into the controller's `DIN`/`tx_start` port, waits for the controller's `tx_ready` completion, and returns a done or timeout status to the owning mailbox. It sits between the host-side mailboxes and `can_controller`, and it is the only driver of the controller's transmit inputs.

## Interface
- `N_MBOX`, default 4: number of mailboxes, valid range 2–8.
- `FRAME_W`, default 108: frame width; matches the controller's `DIN` width.
- `ID_LSB`, default 1: bit position of the identifier LSB inside a frame.
- `ID_W`, default 11: identifier width.
- `HOLD_CYC`, default 256: number of GCLK cycles `can_tx_start` is held; must be at least one controller timeslot, in GCLK cycles.
- `TIMEOUT_CYC`, default 2^20: number of GCLK cycles in WAIT before the scheduler gives up.

- `GCLK` in, 1: the single clock.
- `RES` in, 1: reset, asynchronous and active-high.
- `req` in, N_MBOX: per-mailbox one-cycle request pulse.
- `cancel` in, N_MBOX: per-mailbox one-cycle cancel pulse.
- `frame_in` in, N_MBOX*FRAME_W: mailbox frames, flattened; mailbox k occupies `[k*FRAME_W +: FRAME_W]`. Must stay stable while that mailbox is pending.
- `pending` out, N_MBOX: registered pending flags.
- `done` out, N_MBOX: one-cycle pulse when the mailbox's frame has been sent.
- `err` out, N_MBOX: one-cycle pulse when the mailbox's frame timed out.
- `busy` out, 1: high in every state except IDLE.
- `retries` out, 8: number of `can_rx_ready` rising edges seen during the current WAIT, saturating at 255.
- `can_din` out, FRAME_W: registered frame driven to the controller's `DIN`.
- `can_tx_start` out, 1: driven to the controller's `tx_start`.
- `can_tx_ready` in, 1: from the controller's `tx_ready`.
- `can_rx_ready` in, 1: from the controller's `rx_ready`.

## Operation
- **Reset values:** `pending`=0, `done`=0, `err`=0, `busy`=0, `retries`=0, `can_din`=0, `can_tx_start`=0, state=IDLE, `sel`=0, all counters 0.
- **Request and cancel handling:**
  - `req[k]` sets `pending[k]`.
  - `req[k]` while `pending[k]` is already set is ignored.
  - `cancel[k]` clears `pending[k]` only if k is not the in-flight mailbox. A cancel of the in-flight mailbox is ignored.
  - `req[k]` and `cancel[k]` in the same cycle: cancel wins.
- **Priority selection (combinational):** among pending mailboxes, the winner has the lowest `frame_in[k][ID_LSB +: ID_W]`. Equal IDs resolve to the lowest index k.
- **State machine:**
  - IDLE: if `pending` is non-zero, go to LOAD.
  - LOAD (1 cycle): latch the winner into `sel`, copy its frame into `can_din`, clear `retries`; go to ARM.
  - ARM: `can_tx_start`=1 for exactly `HOLD_CYC` cycles; then drive `can_tx_start`=0 and go to WAIT.
  - WAIT:
    - A rising edge of `can_tx_ready` (registered previous value 0, current 1): go to DONE.
    - Otherwise, when the timeout counter reaches `TIMEOUT_CYC`-1: go to FAIL.
    - Each rising edge of `can_rx_ready` increments `retries` (saturating).
  - DONE (1 cycle): `done[sel]`=1, clear `pending[sel]`; go to IDLE.
  - FAIL (1 cycle): `err[sel]`=1, clear `pending[sel]`; go to IDLE. The controller keeps its buffered frame; recovering the controller is a system-level `RES`.
- **Preemption:** none. A higher-priority request arriving after LOAD waits for the next IDLE.
- `can_din` holds its value from LOAD until the next LOAD.
- **Edge-detect registers:** the registered copies of `can_tx_ready` and `can_rx_ready` reset to 0.
- **Controller reset behaviour:** the controller resets `tx_ready` to 0. A rising edge seen in IDLE or ARM is discarded; only edges during WAIT count.

## Timing
- `req` pulse to `pending` high: 1 cycle.
- `req` to `can_tx_start` high, from IDLE: 3 cycles (pending, then LOAD, then ARM).
- `can_tx_start` high duration: exactly `HOLD_CYC` cycles.
- `can_tx_ready` rising edge in WAIT to `done` pulse: 2 cycles (edge-detect register, then DONE).
- `done`/`err` to the next `can_tx_start`: 3 cycles minimum (IDLE, LOAD, ARM).
- Asynchronous `RES` at any point clears everything immediately, including a frame in flight, with no `done` or `err` pulse.
- **Counter widths:**
  - ARM counter: $clog2(HOLD_CYC+1) bits.
  - WAIT counter: $clog2(TIMEOUT_CYC+1) bits.
  - Neither counter wraps: each is cleared on state entry.

## Structure
- Shared package `can_pkg`:
  - `CAN_FRAME_W`=108.
  - `CAN_ID_LSB` and `CAN_ID_W`.
  - Scheduler state enum: IDLE, LOAD, ARM, WAIT, DONE, FAIL.
  - Frame typedef, used also by `can_controller` wrappers.
- Sub-module `can_prio_select`: combinational lowest-ID/lowest-index arbiter over `pending` and the ID fields. Outputs `win_idx` and `win_valid`.
- FSM, counters and mailbox flags live in the top module.

## Test plan
- **Single request:** `req[2]` with ID 0x123, model acks with a `can_tx_ready` rise 500 cycles after `tx_start` falls. Required: `can_din` equals mailbox 2's frame, `can_tx_start` high for 256 cycles, `done[2]` pulses, `pending`=0.
- **Priority:** `req[0]` with ID 0x400 and `req[3]` with ID 0x010 in the same cycle. Required: mailbox 3 sent first, then mailbox 0. Equal IDs on mailboxes 1 and 2: mailbox 1 sent first.
- **Cancel:** `cancel[1]` while mailbox 1 is pending but not selected clears `pending[1]` with no `done`. `cancel[sel]` during WAIT is ignored and `done[sel]` still arrives.
- **Retry count and timeout:** 3 `can_rx_ready` pulses during WAIT give `retries`=3. With `TIMEOUT_CYC`=1000 and no `can_tx_ready` rise, `err[sel]` pulses at cycle 1000 of WAIT and `pending[sel]` clears.
- **Async reset mid-ARM:** assert `RES` for 3 cycles in the middle of ARM. Required: all outputs at reset values during `RES`, no `done`/`err` pulse, and a fresh `req` after release is serviced normally.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN definitions: frame geometry and transmit scheduler states.
package can_pkg;

  localparam int CAN_FRAME_W = 108;
  localparam int CAN_ID_LSB  = 1;
  localparam int CAN_ID_W    = 11;

  typedef logic [CAN_FRAME_W-1:0] can_frame_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    ARM  = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4,
    FAIL = 3'd5
  } sched_state_t;

endpackage

// File: rtl/can_prio_select.sv
// Combinational arbiter: lowest identifier among pending mailboxes wins, ties go to the lowest index.
module can_prio_select #(
  parameter int N_MBOX = 4,
  parameter int ID_W   = 11
) (
  input  logic [N_MBOX-1:0]         pending,
  input  logic [N_MBOX*ID_W-1:0]    ids,
  output logic [$clog2(N_MBOX)-1:0] win_idx,
  output logic                      win_valid
);

  localparam int IDX_W = $clog2(N_MBOX);

  logic [ID_W-1:0] best_id;

  // Strict less-than keeps the earlier (lower) index on equal identifiers.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    best_id   = '0;
    for (int k = 0; k < N_MBOX; k++) begin
      if (pending[k] && (!win_valid || (ids[k*ID_W +: ID_W] < best_id))) begin
        win_valid = 1'b1;
        win_idx   = IDX_W'(k);
        best_id   = ids[k*ID_W +: ID_W];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Transmit scheduler: picks the lowest-ID pending mailbox, drives it into the CAN controller
// and reports done or timeout back to the owning mailbox.
//
//   state | meaning
//   IDLE  | nothing in flight, waiting for any pending flag
//   LOAD  | latch winner into sel and can_din, clear retries
//   ARM   | can_tx_start held high for HOLD_CYC cycles
//   WAIT  | waiting for a tx_ready rise, counting rx_ready rises, timeout running
//   DONE  | done pulse visible, pending[sel] already cleared
//   FAIL  | err pulse visible, pending[sel] already cleared
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int N_MBOX      = 4,
  parameter int FRAME_W     = CAN_FRAME_W,
  parameter int ID_LSB      = CAN_ID_LSB,
  parameter int ID_W        = CAN_ID_W,
  parameter int HOLD_CYC    = 256,
  parameter int TIMEOUT_CYC = 1 << 20
) (
  input  logic                      GCLK,
  input  logic                      RES,
  input  logic [N_MBOX-1:0]         req,
  input  logic [N_MBOX-1:0]         cancel,
  input  logic [N_MBOX*FRAME_W-1:0] frame_in,
  output logic [N_MBOX-1:0]         pending,
  output logic [N_MBOX-1:0]         done,
  output logic [N_MBOX-1:0]         err,
  output logic                      busy,
  output logic [7:0]                retries,
  output logic [FRAME_W-1:0]        can_din,
  output logic                      can_tx_start,
  input  logic                      can_tx_ready,
  input  logic                      can_rx_ready
);

  localparam int IDX_W  = $clog2(N_MBOX);
  localparam int ARM_W  = $clog2(HOLD_CYC + 1);
  localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

  sched_state_t         state;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W-1:0]     win_idx;
  logic                 win_valid;
  logic [ARM_W-1:0]     arm_cnt;
  logic [WAIT_W-1:0]    wait_cnt;
  logic                 tx_ready_q;
  logic                 tx_rise_q;
  logic                 rx_ready_q;
  logic                 rx_rise;
  logic [N_MBOX*ID_W-1:0] ids;
  logic [FRAME_W-1:0]   win_frame;
  logic [N_MBOX-1:0]    inflight;
  logic [N_MBOX-1:0]    sel_mask;
  logic [N_MBOX-1:0]    pend_next;

  always_comb begin
    ids       = '0;
    win_frame = '0;
    for (int k = 0; k < N_MBOX; k++) begin
      ids[k*ID_W +: ID_W] = frame_in[k*FRAME_W + ID_LSB +: ID_W];
      if (win_idx == IDX_W'(k)) win_frame = frame_in[k*FRAME_W +: FRAME_W];
    end
  end

  can_prio_select #(
    .N_MBOX (N_MBOX),
    .ID_W   (ID_W)
  ) u_prio (
    .pending   (pending),
    .ids       (ids),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  // During LOAD the winner is the mailbox about to be latched, so it is already protected from cancel.
  always_comb begin
    inflight = '0;
    sel_mask = '0;
    sel_mask[sel] = 1'b1;
    if (state == LOAD)      inflight[win_idx] = win_valid;
    else if (state != IDLE) inflight[sel]     = 1'b1;
    pend_next = (pending | req) & ~(cancel & ~inflight);
  end

  assign rx_rise = can_rx_ready & ~rx_ready_q;

  always_ff @(posedge GCLK or posedge RES) begin
    if (RES) begin
      state        <= IDLE;
      sel          <= '0;
      pending      <= '0;
      done         <= '0;
      err          <= '0;
      busy         <= 1'b0;
      retries      <= '0;
      can_din      <= '0;
      can_tx_start <= 1'b0;
      arm_cnt      <= '0;
      wait_cnt     <= '0;
      tx_ready_q   <= 1'b0;
      tx_rise_q    <= 1'b0;
      rx_ready_q   <= 1'b0;
    end else begin
      tx_ready_q <= can_tx_ready;
      rx_ready_q <= can_rx_ready;
      // Only completion edges that arrive while waiting are allowed to finish a frame.
      tx_rise_q  <= can_tx_ready & ~tx_ready_q & (state == WAIT);
      done       <= '0;
      err        <= '0;
      pending    <= pend_next;
      case (state)
        IDLE: begin
          if (|pending) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          if (win_valid) begin
            sel          <= win_idx;
            can_din      <= win_frame;
            retries      <= '0;
            arm_cnt      <= ARM_W'(HOLD_CYC - 1);
            can_tx_start <= 1'b1;
            state        <= ARM;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        ARM: begin
          if (arm_cnt == '0) begin
            can_tx_start <= 1'b0;
            wait_cnt     <= WAIT_W'(TIMEOUT_CYC - 1);
            state        <= WAIT;
          end else begin
            arm_cnt <= arm_cnt - 1'b1;
          end
        end
        WAIT: begin
          if (rx_rise && (retries != 8'hFF)) retries <= retries + 8'd1;
          if (tx_rise_q) begin
            done    <= sel_mask;
            pending <= pend_next & ~sel_mask;
            state   <= DONE;
          end else if (wait_cnt == '0) begin
            err     <= sel_mask;
            pending <= pend_next & ~sel_mask;
            state   <= FAIL;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        DONE, FAIL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: vector table plus hand-written priority/cancel/reset sequences.
module tb_can_tx_scheduler;

  localparam int NMB   = 4;
  localparam int FW    = 108;
  localparam int IDL   = 1;
  localparam int IDW   = 11;
  localparam int HOLD  = 256;
  localparam int TMO   = 1000;

  logic              GCLK = 1'b0;
  logic              RES  = 1'b1;
  logic [NMB-1:0]    req = '0, cancel = '0;
  logic [FW-1:0]     frm [NMB];
  logic [NMB*FW-1:0] frame_in;
  logic [NMB-1:0]    pending, done, err;
  logic              busy, can_tx_start;
  logic [7:0]        retries;
  logic [FW-1:0]     can_din;
  logic              can_tx_ready = 1'b0, can_rx_ready = 1'b0;

  assign frame_in = {frm[3], frm[2], frm[1], frm[0]};

  always #5 GCLK = ~GCLK;

  can_tx_scheduler #(
    .N_MBOX(NMB), .FRAME_W(FW), .ID_LSB(IDL), .ID_W(IDW),
    .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)
  ) dut (
    .GCLK(GCLK), .RES(RES), .req(req), .cancel(cancel), .frame_in(frame_in),
    .pending(pending), .done(done), .err(err), .busy(busy), .retries(retries),
    .can_din(can_din), .can_tx_start(can_tx_start),
    .can_tx_ready(can_tx_ready), .can_rx_ready(can_rx_ready)
  );

  typedef struct {
    int          mbox;
    bit          is_err;
    logic [FW-1:0] frame;
  } exp_t;

  typedef struct {
    int          mbox;
    logic [IDW-1:0] id;
    int          ack_delay;
    int          n_rx;
    int          exp_retries;
    bit          exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[4];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge GCLK);
    #1;
  endtask

  function automatic logic [FW-1:0] make_frame(input logic [IDW-1:0] id);
    logic [FW-1:0] f;
    f[31:0]   = $urandom;
    f[63:32]  = $urandom;
    f[95:64]  = $urandom;
    f[107:96] = 12'($urandom);
    f[IDL +: IDW] = id;
    return f;
  endfunction

  task automatic push(input int mb, input bit is_err);
    exp_t e;
    e.mbox = mb;
    e.is_err = is_err;
    e.frame = frm[mb];
    sb.push_back(e);
  endtask

  // Scoreboard: every done/err pulse must match the oldest expected completion.
  always @(negedge GCLK) begin
    if (!RES && ((done != '0) || (err != '0))) begin
      if (sb.size() == 0) begin
        check("unexpected_completion", {done, err}, '0);
      end else begin
        exp_t e;
        logic [NMB-1:0] m;
        e = sb.pop_front();
        m = 4'b0001 << e.mbox;
        check("done_mask", done, e.is_err ? 4'b0000 : m);
        check("err_mask",  err,  e.is_err ? m : 4'b0000);
        check("can_din",   can_din, e.frame);
        check("pending_cleared", pending & m, '0);
      end
    end
  end

  // Plays the controller for one frame: hold check, rx pulses, optional cancel, then ack or timeout.
  task automatic serve(input int ack_delay, input int n_rx, input logic [NMB-1:0] cmask);
    int n;
    int used;
    n = 0;
    while (!can_tx_start && n < 200) begin tick(); n++; end
    if (!can_tx_start) check("tx_start_seen", 0, 1);
    n = 0;
    while (can_tx_start && n < 1000) begin tick(); n++; end
    check("hold_cycles", n, HOLD);
    used = 0;
    if (cmask != '0) begin
      cancel = cmask; tick(); cancel = '0; used++;
      check("inflight_cancel_ignored", pending & cmask, cmask);
    end
    for (int i = 0; i < n_rx; i++) begin
      can_rx_ready = 1'b1; tick();
      can_rx_ready = 1'b0; tick();
      used += 2;
    end
    if (ack_delay >= 0) begin
      for (int i = used; i < ack_delay; i++) tick();
      can_tx_ready = 1'b1;
      n = 0;
      while (done == '0 && err == '0 && n < 20) begin tick(); n++; end
      check("ack_to_done", n, 2);
    end else begin
      n = used;
      while (done == '0 && err == '0 && n < 2000) begin tick(); n++; end
      check("timeout_cycles", n, TMO);
    end
    tick();
    can_tx_ready = 1'b0;
    tick();
  endtask

  initial begin
    int n;
    vecs[0] = '{2, 11'h123, 500, 0,   0,   1'b0};
    vecs[1] = '{0, 11'h7FF, 20,  3,   3,   1'b0};
    vecs[2] = '{1, 11'h055, 700, 260, 255, 1'b0};
    vecs[3] = '{3, 11'h010, -1,  0,   0,   1'b1};
    for (int k = 0; k < NMB; k++) frm[k] = make_frame(11'h7FF);

    repeat (3) tick();
    check("rst_pending", pending, '0);
    check("rst_done", done, '0);
    check("rst_err", err, '0);
    check("rst_busy", busy, 0);
    check("rst_retries", retries, 0);
    check("rst_can_din", can_din, '0);
    check("rst_tx_start", can_tx_start, 0);
    RES = 1'b0;
    tick();

    for (int v = 0; v < 4; v++) begin
      frm[vecs[v].mbox] = make_frame(vecs[v].id);
      push(vecs[v].mbox, vecs[v].exp_err);
      req = 4'b0001 << vecs[v].mbox;
      tick();
      req = '0;
      check("pending_set", pending, 4'b0001 << vecs[v].mbox);
      n = 1;
      while (!can_tx_start && n < 20) begin tick(); n++; end
      check("req_to_tx_start", n, 3);
      serve(vecs[v].ack_delay, vecs[v].n_rx, '0);
      check("retries", retries, vecs[v].exp_retries);
      check("pending_idle", pending, '0);
      check("busy_idle", busy, 0);
    end

    // Lower identifier goes first regardless of index.
    frm[0] = make_frame(11'h400);
    frm[3] = make_frame(11'h010);
    push(3, 1'b0);
    push(0, 1'b0);
    req = 4'b1001; tick(); req = '0;
    serve(100, 0, '0);
    serve(100, 0, '0);

    // Equal identifiers: lower index first.
    frm[1] = make_frame(11'h222);
    frm[2] = make_frame(11'h222);
    push(1, 1'b0);
    push(2, 1'b0);
    req = 4'b0110; tick(); req = '0;
    serve(50, 0, '0);
    serve(50, 0, '0);

    // Same-cycle req and cancel: cancel wins.
    req = 4'b0100; cancel = 4'b0100; tick(); req = '0; cancel = '0;
    check("req_cancel_same_cycle", pending, '0);
    repeat (3) tick();
    check("no_start_after_cancel", busy, 0);

    // Cancel a waiting mailbox, then try to cancel the in-flight one.
    frm[0] = make_frame(11'h100);
    frm[1] = make_frame(11'h200);
    push(0, 1'b0);
    req = 4'b0011; tick(); req = '0;
    cancel = 4'b0010; tick(); cancel = '0;
    check("cancel_waiting", pending, 4'b0001);
    serve(300, 0, 4'b0001);
    repeat (10) tick();
    check("no_send_after_cancel", busy, 0);

    // Asynchronous reset in the middle of ARM drops the frame silently.
    frm[2] = make_frame(11'h0AA);
    req = 4'b0100; tick(); req = '0;
    n = 0;
    while (!can_tx_start && n < 20) begin tick(); n++; end
    repeat (100) tick();
    check("mid_arm_tx_start", can_tx_start, 1);
    #2 RES = 1'b1;
    #1;
    check("async_rst_tx_start", can_tx_start, 0);
    check("async_rst_pending", pending, '0);
    check("async_rst_busy", busy, 0);
    check("async_rst_din", can_din, '0);
    repeat (3) tick();
    check("rst_hold_done_err", {done, err}, '0);
    RES = 1'b0;
    tick();
    frm[1] = make_frame(11'h321);
    push(1, 1'b0);
    req = 4'b0010; tick(); req = '0;
    n = 1;
    while (!can_tx_start && n < 20) begin tick(); n++; end
    check("post_rst_req_to_tx_start", n, 3);
    serve(200, 0, '0);

    repeat (5) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
